// File: rtl/wishbone_cmd_queue_if.sv
// Command queue bus bundle: producer command port, wishbone_master user port, response port.
// slave modport is the queue's view; master modport is the surrounding logic's view.
interface wishbone_cmd_queue_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH   = 4
);
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

  // Command producer
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic [CountWidth-1:0]   cmd_count;

  // wishbone_master user port
  logic                    write_req;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [SELECT_WIDTH-1:0] write_sel;
  logic                    write_done;
  logic                    write_err;
  logic                    read_req;
  logic [ADDR_WIDTH-1:0]   read_addr;
  logic [SELECT_WIDTH-1:0] read_sel;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_done;
  logic                    read_err;

  // Response consumer
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_we;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_data;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
    output cmd_ready, cmd_count,
    output write_req, write_addr, write_data, write_sel,
    input  write_done, write_err,
    output read_req, read_addr, read_sel,
    input  read_data, read_done, read_err,
    output rsp_valid, rsp_we, rsp_err, rsp_data,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
    input  cmd_ready, cmd_count,
    input  write_req, write_addr, write_data, write_sel,
    output write_done, write_err,
    input  read_req, read_addr, read_sel,
    output read_data, read_done, read_err,
    input  rsp_valid, rsp_we, rsp_err, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/wishbone_cmd_queue.sv
// Command queue in front of wishbone_master: FIFO of read/write commands, issued one at a time,
// one in-order response per command.
// Optional macro WB_CMDQ_STATS_EN adds saturating 16-bit ok/err completion counters.
module wishbone_cmd_queue #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef WB_CMDQ_STATS_EN
  output logic [15:0]            stat_ok_o,
  output logic [15:0]            stat_err_o,
`endif
  wishbone_cmd_queue_if.slave    bus
);
  localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountWidth = PtrWidth + 1;

  typedef struct packed {
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [SELECT_WIDTH-1:0] sel;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  entry_t                  mem_q [FIFO_DEPTH];
  entry_t                  head;
  logic [PtrWidth-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0]   count_q, count_d;
  logic                    full, empty, push, pop;

  state_e                  state_q;
  logic                    cur_we_q;
  logic                    write_req_q, read_req_q;
  logic [ADDR_WIDTH-1:0]   write_addr_q, read_addr_q;
  logic [DATA_WIDTH-1:0]   write_data_q;
  logic [SELECT_WIDTH-1:0] write_sel_q, read_sel_q;
  logic                    rsp_valid_q, rsp_we_q, rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    done_hit, err_hit;

  assign full  = (count_q == CountWidth'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.cmd_valid && !full;
  // The head entry is consumed during the single ISSUE cycle.
  assign pop   = (state_q == StIssue);
  assign head  = mem_q[rd_ptr_q];

  // Only the flags belonging to the in-flight command type complete it; err dominates done.
  assign done_hit = cur_we_q ? (bus.write_done | bus.write_err) : (bus.read_done | bus.read_err);
  assign err_hit  = cur_we_q ? bus.write_err : bus.read_err;

  // Occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{we: bus.cmd_we, addr: bus.cmd_addr, data: bus.cmd_data,
                           sel: bus.cmd_sel};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      count_q <= count_d;
    end
  end

  // Issue/response FSM with all master-facing and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cur_we_q     <= 1'b0;
      write_req_q  <= 1'b0;
      read_req_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_sel_q  <= '0;
      read_addr_q  <= '0;
      read_sel_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_we_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
`ifdef WB_CMDQ_STATS_EN
      stat_ok_o    <= '0;
      stat_err_o   <= '0;
`endif
    end else begin
      write_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q  <= StIssue;
            cur_we_q <= head.we;
            if (head.we) begin
              write_req_q  <= 1'b1;
              write_addr_q <= head.addr;
              write_data_q <= head.data;
              write_sel_q  <= head.sel;
            end else begin
              read_req_q  <= 1'b1;
              read_addr_q <= head.addr;
              read_sel_q  <= head.sel;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (done_hit) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= cur_we_q;
            rsp_err_q   <= err_hit;
            rsp_data_q  <= (!cur_we_q && !err_hit) ? bus.read_data : '0;
`ifdef WB_CMDQ_STATS_EN
            if (err_hit) begin
              if (stat_err_o != 16'hFFFF) stat_err_o <= stat_err_o + 16'd1;
            end else begin
              if (stat_ok_o != 16'hFFFF) stat_ok_o <= stat_ok_o + 16'd1;
            end
`endif
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.cmd_count  = count_q;
  assign bus.write_req  = write_req_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.write_sel  = write_sel_q;
  assign bus.read_req   = read_req_q;
  assign bus.read_addr  = read_addr_q;
  assign bus.read_sel   = read_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_we     = rsp_we_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_wishbone_cmd_queue.sv
// Directed bench for wishbone_cmd_queue: vector table plus hand-written multi-cycle sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wishbone_cmd_queue;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wishbone_cmd_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW),
                          .FIFO_DEPTH(FD)) bus ();

`ifdef WB_CMDQ_STATS_EN
  logic [15:0] stat_ok, stat_err;
`endif

  wishbone_cmd_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW),
                       .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef WB_CMDQ_STATS_EN
    .stat_ok_o (stat_ok),
    .stat_err_o(stat_err),
`endif
    .bus       (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          delay;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ok = 0;
  int   exp_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output logic got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.write_req || bus.read_req) begin
        got = 1'b1;
        break;
      end
    end
    check("req_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(output logic got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rsp_seen", 32'(got), 32'd1);
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic pulse_flags(input logic we, input logic done, input logic err,
                             input logic [31:0] rdata);
    bus.write_done = we & done;
    bus.write_err  = we & err;
    bus.read_done  = !we & done;
    bus.read_err   = !we & err;
    bus.read_data  = rdata;
    @(negedge clk);
    bus.write_done = 1'b0;
    bus.write_err  = 1'b0;
    bus.read_done  = 1'b0;
    bus.read_err   = 1'b0;
    if (err) exp_errs++;
    else     exp_ok++;
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    push(v.we, v.addr, v.data, v.sel);
    wait_req(got);
    if (got) begin
      if (v.we) begin
        check("write_req", 32'(bus.write_req), 32'd1);
        check("read_req_quiet", 32'(bus.read_req), 32'd0);
        check("write_addr", bus.write_addr, v.addr);
        check("write_data", bus.write_data, v.data);
        check("write_sel", 32'(bus.write_sel), 32'(v.sel));
      end else begin
        check("read_req", 32'(bus.read_req), 32'd1);
        check("write_req_quiet", 32'(bus.write_req), 32'd0);
        check("read_addr", bus.read_addr, v.addr);
        check("read_sel", 32'(bus.read_sel), 32'(v.sel));
      end
      repeat (v.delay) @(negedge clk);
      check("rsp_idle_in_wait", 32'(bus.rsp_valid), 32'd0);
      pulse_flags(v.we, v.done, v.err, v.rdata);
      wait_rsp(got);
      check("rsp_we", 32'(bus.rsp_we), 32'(v.we));
      check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
      check("rsp_data", bus.rsp_data, v.exp_data);
      handshake();
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        got;
    logic        stable;
    logic [31:0] snap;

    //            we    addr    data          sel  dly done  err   rdata         xerr  xdata
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 1, 1'b1, 1'b0, 32'h12345678, 1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 32'h24, 32'h0,        4'hF, 2, 1'b0, 1'b1, 32'hAAAA5555, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h30, 32'h01020304, 4'h3, 1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h34, 32'h0,        4'hC, 1, 1'b1, 1'b1, 32'hFFFF0000, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h38, 32'h55AA55AA, 4'h1, 4, 1'b1, 1'b1, 32'h0,        1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h3C, 32'h0,        4'h3, 1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};

    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.cmd_sel = '0; bus.write_done = 1'b0; bus.write_err = 1'b0; bus.read_done = 1'b0;
    bus.read_err = 1'b0; bus.read_data = '0; bus.rsp_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_cmd_count", 32'(bus.cmd_count), 32'd0);
    check("rst_write_req", 32'(bus.write_req), 32'd0);
    check("rst_read_req", 32'(bus.read_req), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_write_addr", bus.write_addr, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);

    // Latency into an empty queue.
    push(1'b1, 32'h50, 32'h11112222, 4'hF);
    check("lat_req_early", 32'(bus.write_req), 32'd0);
    check("lat_count_1", 32'(bus.cmd_count), 32'd1);
    @(negedge clk);
    check("lat_req_pulse", 32'(bus.write_req), 32'd1);
    @(negedge clk);
    check("lat_req_one_cycle", 32'(bus.write_req), 32'd0);
    check("lat_count_popped", 32'(bus.cmd_count), 32'd0);
    check("lat_addr_held", bus.write_addr, 32'h50);
    pulse_flags(1'b1, 1'b1, 1'b0, 32'h0);
    wait_rsp(got);
    handshake();

    // Table of single-command transactions.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Full FIFO: one command in WAIT, four more stored.
    push(1'b0, 32'h100, 32'h0, 4'hF);
    wait_req(got);
    check("fill_addr0", bus.read_addr, 32'h100);
    for (int i = 1; i < 5; i++) push(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF);
    check("fill_count", 32'(bus.cmd_count), 32'd4);
    check("fill_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("fill_no_req", 32'(bus.read_req | bus.write_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_req(got);
        check("fill_order_addr", bus.read_addr, 32'h100 + 32'(i * 4));
        @(negedge clk);
      end
      pulse_flags(1'b0, 1'b1, 1'b0, 32'hA0000000 + 32'(i));
      wait_rsp(got);
      check("fill_rsp_data", bus.rsp_data, 32'hA0000000 + 32'(i));
      handshake();
    end
    check("fill_drained", 32'(bus.cmd_count), 32'd0);

    // Errored read, response stalled 10 cycles, queued write still issued afterwards.
    push(1'b0, 32'h40, 32'h0, 4'hF);
    wait_req(got);
    push(1'b1, 32'h44, 32'h00000055, 4'h3);
    check("stall_count", 32'(bus.cmd_count), 32'd1);
    pulse_flags(1'b0, 1'b0, 1'b1, 32'hBAD0BAD0);
    wait_rsp(got);
    check("stall_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("stall_rsp_data", bus.rsp_data, 32'd0);
    snap = bus.rsp_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_we || !bus.rsp_err || bus.rsp_data != snap ||
          bus.write_req || bus.read_req) stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    check("stall_count_kept", 32'(bus.cmd_count), 32'd1);
    handshake();
    check("gap_idle_no_req", 32'(bus.write_req | bus.read_req), 32'd0);
    wait_req(got);
    check("after_err_write_req", 32'(bus.write_req), 32'd1);
    check("after_err_addr", bus.write_addr, 32'h44);
    check("after_err_sel", 32'(bus.write_sel), 32'h3);
    @(negedge clk);
    pulse_flags(1'b1, 1'b1, 1'b0, 32'h0);
    wait_rsp(got);
    check("after_err_rsp_err", 32'(bus.rsp_err), 32'd0);
    handshake();

`ifdef WB_CMDQ_STATS_EN
    check("stat_ok", 32'(stat_ok), 32'(exp_ok));
    check("stat_err", 32'(stat_err), 32'(exp_errs));
`endif

    // Reset while a command is in WAIT with another queued.
    push(1'b1, 32'h200, 32'h77777777, 4'hF);
    wait_req(got);
    push(1'b0, 32'h204, 32'h0, 4'hF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.cmd_count), 32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst_req", 32'(bus.write_req | bus.read_req), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_write_addr", bus.write_addr, 32'd0);
    check("mid_rst_write_data", bus.write_data, 32'd0);
`ifdef WB_CMDQ_STATS_EN
    check("mid_rst_stats", 32'({stat_ok, stat_err}), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.write_req || bus.read_req || bus.rsp_valid || bus.cmd_count != 0) stable = 1'b0;
    end
    check("post_rst_quiet", 32'(stable), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
